// File: rtl/ir_fetch.sv
// ir_fetch: instruction fetch unit with a held instruction register (IR).
// Issues one instruction-memory request per fetch_start_i accepted in IDLE,
// loads the returned word into the IR, pulses fetch_done_o, and decodes
// the IR fields plus the immediate-extension mode for the extender.
//
// Optional feature, macro FETCH_TIMEOUT_EN:
//   defined   -> a 4-bit wait counter moves the FSM to a sticky ERR state
//                after 16 consecutive REQ cycles without imem_ready_i.
//   undefined -> REQ waits forever, ERR is unreachable and fetch_err_o is 0.
module ir_fetch (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        fetch_start_i,
    input  logic [31:0] pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_o,
    output logic [5:0]  opcode_o,
    output logic [4:0]  rs_o,
    output logic [4:0]  rt_o,
    output logic [4:0]  rd_o,
    output logic [4:0]  shamt_o,
    output logic [5:0]  funct_o,
    output logic [15:0] Ext_offset_o,
    output logic [1:0]  Eoff_sign_o,
    output logic        busy_o,
    output logic        fetch_done_o,
    output logic        instr_valid_o,
    output logic        fetch_err_o
);

    // Extension modes understood by the immediate extender.
    localparam logic [1:0] EXT_ZERO  = 2'b00;
    localparam logic [1:0] EXT_UPPER = 2'b01;
    localparam logic [1:0] EXT_SIGN  = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] addr_q;
    logic [31:0] ir_q;
    logic        valid_q;
    logic [1:0]  ext_mode;

`ifdef FETCH_TIMEOUT_EN
    logic [3:0]  wait_cnt;
    logic        err_q;
    // A wait count of 15 means this is the 16th REQ cycle without ready.
    logic        wait_expired;
    assign wait_expired = (wait_cnt == 4'hF);
`endif

    // State register; reset wins over everything, including a pending ready.
    always_ff @(posedge clk_i) begin
        if (reset_i) state <= IDLE;
        else         state <= state_next;
    end

    // Next-state logic; start is only honoured in IDLE, ready only in REQ.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (fetch_start_i) state_next = REQ;
            REQ: begin
                if (imem_ready_i) state_next = DONE;
`ifdef FETCH_TIMEOUT_EN
                else if (wait_expired) state_next = ERR;
`endif
            end
            DONE: state_next = IDLE;
`ifdef FETCH_TIMEOUT_EN
            ERR:  state_next = ERR;
`else
            ERR:  state_next = IDLE;
`endif
            default: state_next = IDLE;
        endcase
    end

    // Output decode; reset_i forces the handshake outputs low in the same cycle.
    always_comb begin
        imem_req_o   = 1'b0;
        busy_o       = 1'b0;
        fetch_done_o = 1'b0;
        if (!reset_i) begin
            case (state)
                REQ: begin
                    imem_req_o = 1'b1;
                    busy_o     = 1'b1;
                end
                DONE: begin
                    busy_o       = 1'b1;
                    fetch_done_o = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Address capture on accepted start; IR load and valid flag on the ready edge.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            addr_q  <= 32'h0;
            ir_q    <= 32'h0;
            valid_q <= 1'b0;
        end else begin
            if (state == IDLE && fetch_start_i)
                addr_q <= pc_i;
            if (state == REQ && imem_ready_i) begin
                ir_q    <= imem_rdata_i;
                valid_q <= 1'b1;
            end
        end
    end

`ifdef FETCH_TIMEOUT_EN
    // Wait counter: cleared on entry to REQ, counts REQ cycles without ready.
    always_ff @(posedge clk_i) begin
        if (reset_i)
            wait_cnt <= 4'h0;
        else if (state != REQ && state_next == REQ)
            wait_cnt <= 4'h0;
        else if (state == REQ && !imem_ready_i)
            wait_cnt <= wait_cnt + 4'h1;
    end

    // Sticky error flag, set on the edge that enters ERR.
    always_ff @(posedge clk_i) begin
        if (reset_i)
            err_q <= 1'b0;
        else if (state_next == ERR)
            err_q <= 1'b1;
    end

    assign fetch_err_o = err_q;
`else
    assign fetch_err_o = 1'b0;
`endif

    // Extension mode from the IR opcode: logical immediates zero-extend,
    // lui shifts up, branches/arith immediates/loads/stores sign-extend.
    always_comb begin
        ext_mode = EXT_ZERO;
        case (ir_q[31:26])
            6'h0C, 6'h0D, 6'h0E: ext_mode = EXT_ZERO;
            6'h0F:               ext_mode = EXT_UPPER;
            6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B,
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25,
            6'h28, 6'h29, 6'h2B: ext_mode = EXT_SIGN;
            default:             ext_mode = EXT_ZERO;
        endcase
    end

    assign Eoff_sign_o   = reset_i ? EXT_ZERO : ext_mode;
    assign imem_addr_o   = addr_q;
    assign instr_valid_o = valid_q;
    assign instr_o       = ir_q;
    assign opcode_o      = ir_q[31:26];
    assign rs_o          = ir_q[25:21];
    assign rt_o          = ir_q[20:16];
    assign rd_o          = ir_q[15:11];
    assign shamt_o       = ir_q[10:6];
    assign funct_o       = ir_q[5:0];
    assign Ext_offset_o  = ir_q[15:0];

endmodule

// File: tb/tb_ir_fetch.sv
// Directed bench for ir_fetch: linear sequence of steps, each checked with
// an immediate assertion against hand-computed values.
module tb_ir_fetch;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        fetch_start_i;
    logic [31:0] pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] instr_o;
    logic [5:0]  opcode_o;
    logic [4:0]  rs_o, rt_o, rd_o, shamt_o;
    logic [5:0]  funct_o;
    logic [15:0] Ext_offset_o;
    logic [1:0]  Eoff_sign_o;
    logic        busy_o, fetch_done_o, instr_valid_o, fetch_err_o;

    int n_cmp  = 0;
    int n_fail = 0;
    int req_cycles;

    ir_fetch dut (
        .clk_i(clk), .reset_i(reset_i), .fetch_start_i(fetch_start_i), .pc_i(pc_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_ready_i(imem_ready_i), .imem_rdata_i(imem_rdata_i),
        .instr_o(instr_o), .opcode_o(opcode_o), .rs_o(rs_o), .rt_o(rt_o),
        .rd_o(rd_o), .shamt_o(shamt_o), .funct_o(funct_o),
        .Ext_offset_o(Ext_offset_o), .Eoff_sign_o(Eoff_sign_o),
        .busy_o(busy_o), .fetch_done_o(fetch_done_o),
        .instr_valid_o(instr_valid_o), .fetch_err_o(fetch_err_o)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are then sampled 1 time unit past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Start a fetch, wait 'waits' REQ cycles without ready, then return data.
    // Leaves the DUT in DONE; counts cycles with imem_req_o high.
    task automatic do_fetch(input logic [31:0] pc, input logic [31:0] data, input int waits);
        pc_i          = pc;
        fetch_start_i = 1'b1;
        tick();
        fetch_start_i = 1'b0;
        req_cycles    = 0;
        for (int i = 0; i <= waits; i++) begin
            if (imem_req_o) req_cycles++;
            imem_ready_i = (i == waits);
            imem_rdata_i = (i == waits) ? data : 32'hBAD0_0000;
            tick();
        end
        imem_ready_i = 1'b0;
    endtask

    initial begin
        reset_i = 1'b1; fetch_start_i = 1'b0; pc_i = 32'h0;
        imem_ready_i = 1'b0; imem_rdata_i = 32'h0;
        tick(); tick();

        // Reset state, observed while reset_i is still high.
        chk("rst_req",   {31'h0, imem_req_o},    32'h0);
        chk("rst_busy",  {31'h0, busy_o},        32'h0);
        chk("rst_done",  {31'h0, fetch_done_o},  32'h0);
        chk("rst_eoff",  {30'h0, Eoff_sign_o},   32'h0);
        chk("rst_ir",    instr_o,                32'h0);
        chk("rst_addr",  imem_addr_o,            32'h0);
        chk("rst_valid", {31'h0, instr_valid_o}, 32'h0);
        chk("rst_err",   {31'h0, fetch_err_o},   32'h0);
        reset_i = 1'b0;
        tick();

        // lui, minimum latency: start at N, req at N+1, done at N+2.
        pc_i = 32'h0000_3000; fetch_start_i = 1'b1;
        tick();
        fetch_start_i = 1'b0;
        chk("t1_req",  {31'h0, imem_req_o}, 32'h1);
        chk("t1_addr", imem_addr_o,         32'h0000_3000);
        chk("t1_busy", {31'h0, busy_o},     32'h1);
        chk("t1_ir_held", instr_o,          32'h0);
        imem_ready_i = 1'b1; imem_rdata_i = 32'h3C01_1234;
        tick();
        imem_ready_i = 1'b0;
        chk("t1_done",  {31'h0, fetch_done_o},  32'h1);
        chk("t1_ir",    instr_o,                32'h3C01_1234);
        chk("t1_off",   {16'h0, Ext_offset_o},  32'h0000_1234);
        chk("t1_eoff",  {30'h0, Eoff_sign_o},   32'h1);
        chk("t1_valid", {31'h0, instr_valid_o}, 32'h1);
        chk("t1_req_lo",{31'h0, imem_req_o},    32'h0);
        tick();
        chk("t1_done_pulse", {31'h0, fetch_done_o}, 32'h0);
        chk("t1_idle_busy",  {31'h0, busy_o},       32'h0);
        chk("t1_valid_hold", {31'h0, instr_valid_o},32'h1);

        // Ready while idle is ignored.
        imem_ready_i = 1'b1; imem_rdata_i = 32'hFFFF_FFFF;
        tick();
        imem_ready_i = 1'b0;
        chk("idle_ready_ir",   instr_o,         32'h3C01_1234);
        chk("idle_ready_busy", {31'h0, busy_o}, 32'h0);

        // addiu with 3 wait cycles: request high 4 cycles, sign extension.
        do_fetch(32'h0000_3004, 32'h2408_FFFC, 3);
        chk("t2_req_cycles", req_cycles,             32'd4);
        chk("t2_done",       {31'h0, fetch_done_o},  32'h1);
        chk("t2_addr",       imem_addr_o,            32'h0000_3004);
        chk("t2_eoff",       {30'h0, Eoff_sign_o},   32'h2);
        chk("t2_rt",         {27'h0, rt_o},          32'd8);
        chk("t2_off",        {16'h0, Ext_offset_o},  32'h0000_FFFC);
        tick();

        // ori zero-extends.
        do_fetch(32'h0000_3008, 32'h3508_FFFF, 0);
        chk("t3_eoff", {30'h0, Eoff_sign_o}, 32'h0);
        chk("t3_op",   {26'h0, opcode_o},    32'h0D);
        tick();

        // R-type add $2,$4,$5.
        do_fetch(32'h0000_300C, 32'h0085_1020, 1);
        chk("t4_rs",    {27'h0, rs_o},        32'd4);
        chk("t4_rt",    {27'h0, rt_o},        32'd5);
        chk("t4_rd",    {27'h0, rd_o},        32'd2);
        chk("t4_shamt", {27'h0, shamt_o},     32'd0);
        chk("t4_funct", {26'h0, funct_o},     32'h20);
        chk("t4_eoff",  {30'h0, Eoff_sign_o}, 32'h0);
        tick();

        // Start pulsed in REQ and in DONE is ignored: no extra request.
        pc_i = 32'h0000_4000; fetch_start_i = 1'b1;
        tick();
        pc_i = 32'h0000_5000;                // start still high in REQ
        tick();
        chk("t5_addr_stable", imem_addr_o, 32'h0000_4000);
        fetch_start_i = 1'b0; imem_ready_i = 1'b1; imem_rdata_i = 32'h8C82_0004;
        tick();
        imem_ready_i = 1'b0;
        chk("t5_done", {31'h0, fetch_done_o}, 32'h1);
        chk("t5_eoff", {30'h0, Eoff_sign_o},  32'h2);
        fetch_start_i = 1'b1;                // start while in DONE
        tick();
        fetch_start_i = 1'b0;
        chk("t5_no_req",  {31'h0, imem_req_o}, 32'h0);
        chk("t5_no_busy", {31'h0, busy_o},     32'h0);
        tick();
        chk("t5_still_idle", {31'h0, imem_req_o}, 32'h0);

        // Reset in the 2nd REQ cycle with ready high: data discarded.
        pc_i = 32'h0000_6000; fetch_start_i = 1'b1;
        tick();
        fetch_start_i = 1'b0;
        tick();
        reset_i = 1'b1; imem_ready_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
        #1;
        chk("t6_rst_req_now",  {31'h0, imem_req_o}, 32'h0);
        chk("t6_rst_busy_now", {31'h0, busy_o},     32'h0);
        tick();
        reset_i = 1'b0; imem_ready_i = 1'b0;
        chk("t6_ir",    instr_o,                32'h0);
        chk("t6_valid", {31'h0, instr_valid_o}, 32'h0);
        chk("t6_addr",  imem_addr_o,            32'h0);
        #1;
        chk("t6_req",   {31'h0, imem_req_o},    32'h0);
        chk("t6_busy",  {31'h0, busy_o},        32'h0);
        tick();

`ifdef FETCH_TIMEOUT_EN
        // Ready on the 16th waiting cycle still completes.
        do_fetch(32'h0000_7000, 32'h2402_0001, 15);
        chk("to_ok_done", {31'h0, fetch_done_o}, 32'h1);
        chk("to_ok_err",  {31'h0, fetch_err_o},  32'h0);
        chk("to_ok_ir",   instr_o,               32'h2402_0001);
        tick();
        // 16 cycles without ready: sticky error, IR unchanged.
        pc_i = 32'h0000_7004; fetch_start_i = 1'b1;
        tick();
        fetch_start_i = 1'b0;
        for (int i = 0; i < 16; i++) tick();
        chk("to_err",    {31'h0, fetch_err_o}, 32'h1);
        chk("to_req",    {31'h0, imem_req_o},  32'h0);
        chk("to_ir",     instr_o,              32'h2402_0001);
        imem_ready_i = 1'b1; fetch_start_i = 1'b1;
        tick(); tick();
        imem_ready_i = 1'b0; fetch_start_i = 1'b0;
        chk("to_sticky", {31'h0, fetch_err_o}, 32'h1);
        chk("to_ir2",    instr_o,              32'h2402_0001);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        chk("to_rst_err", {31'h0, fetch_err_o}, 32'h0);
`else
        // Without the timeout, a long wait keeps requesting with no error.
        pc_i = 32'h0000_7000; fetch_start_i = 1'b1;
        tick();
        fetch_start_i = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("nt_req", {31'h0, imem_req_o},  32'h1);
        chk("nt_err", {31'h0, fetch_err_o}, 32'h0);
        imem_ready_i = 1'b1; imem_rdata_i = 32'h3C0A_8000;
        tick();
        imem_ready_i = 1'b0;
        chk("nt_done", {31'h0, fetch_done_o}, 32'h1);
        chk("nt_ir",   instr_o,               32'h3C0A_8000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Global time bound so the run can never hang.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
